mcpu_ram_arbiter: RTL
=====================

// Module: mcpu_ram_arbiter
// PURPOSE
//  Two-requester arbiter for the MCPU's single-port 256x16 RAM. Port 0 is the CPU
//  load/store/fetch path; port 1 is the program loader/debug path. One command per
//  cycle, in order, pipelined to a synchronous-read RAM. Round-robin fairness,
//  optional bus lock with a forced-release limit.
// PARAMETERS
//  ADDR_WIDTH  8   RAM address width (256 words)
//  DATA_WIDTH  16  RAM word width (matches instruction word)
//  LOCK_MAX    15  max consecutive locked grants to one port before forced release (>=1)
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-low (0 = reset)
//  req0/req1  in   1           request valid, port 0/1
//  we0/we1    in   1           1 = write, 0 = read
//  lock0/1    in   1           hold grant for the next access by the same port
//  addr0/1    in   ADDR_WIDTH  word address
//  wdata0/1   in   DATA_WIDTH  write data
//  gnt0/gnt1  out  1           request accepted this cycle (combinational)
//  rvalid0/1  out  1           read data valid for port 0/1
//  rdata      out  DATA_WIDTH  read data, shared; qualified by rvalid0/1
//  ram_en     out  1           RAM command valid (registered)
//  ram_we     out  1           RAM write enable (registered)
//  ram_addr   out  ADDR_WIDTH  RAM address (registered)
//  ram_wdata  out  DATA_WIDTH  RAM write data (registered)
//  ram_rdata  in   DATA_WIDTH  RAM read data, valid the cycle after ram_en&!ram_we
// BEHAVIOUR
//  - Reset (reset=0, async): ram_en/ram_we/rvalid0/rvalid1=0, ram_addr/ram_wdata=0,
//    rr_ptr=port0 preferred, lock owner=none, lock_cnt=0. In-flight reads discarded.
//  - At most one gnt per cycle; gntN=0 whenever reqN=0. Requesters hold req/addr/data
//    until gnt.
//  - Pipeline: gnt in cycle T -> ram_* command in T+1 -> for reads, rvalidN=1 and
//    rdata=ram_rdata in T+2. Read latency 2 cycles; throughput 1 access/cycle.
//  - rdata driven straight from ram_rdata; rvalidN is a 2-stage registered tag.
//  - Order preserved: write then read same address on consecutive grants returns
//    the new data (RAM write-first on ordering, arbiter never reorders).
//  - Writes produce no rvalid.
//  - Arbitration when unlocked: single requester wins; both -> port rr_ptr wins,
//    then rr_ptr moves to the other port. A lone grant also sets rr_ptr to the other.
//  - Lock: grant with lockN=1 makes N owner; while owned only N can be granted,
//    other port stalls. Owner released on a grant with lockN=0, or when lock_cnt
//    reaches LOCK_MAX (that grant still completes; rr_ptr forced to other port).
//    lock_cnt counts granted locked beats, cleared on release.
//  - Owner dropping req while locked: lock held, no grants issued (no timeout).
//  - reset asserted mid-pipeline: pending rvalid never issued; restart clean.
//  States: UNLOCKED, LOCKED0, LOCKED1.
// CONFIGURATION
//  MCPU_ARB_FIXED_PRIO_EN defined: unlocked conflicts always granted to port 0;
//  rr_ptr unused; lock logic unchanged. Undefined (default): round-robin as above.
// TESTING
//  1. Reset 0x00..0xFF zero; port1 writes 0x0064=0x0030 -> gnt1 same cycle, ram_we=1
//     addr 0x64 next cycle; port0 read 0x64 -> rvalid0 2 cycles after gnt0, rdata=0x0030.
//  2. req0 and req1 held 6 cycles unlocked -> grants alternate 0,1,0,1,0,1.
//  3. port1 lock1=1 for 20 beats, req0 held -> port1 gets 15 grants, port0 granted
//     next, then alternation resumes.
//  4. Back-to-back port0 write 0x65=0x0013 then read 0x65 -> rdata=0x0013.
//  5. reset pulsed low 1 cycle after a read grant -> no rvalid, all outputs 0.
//  6. With MCPU_ARB_FIXED_PRIO_EN, both requesting 4 cycles -> gnt0 all 4 cycles.

Source files
------------

// File: rtl/mcpu_ram_arbiter_if.sv
// mcpu_ram_arbiter_if: requester and RAM-side bus of the MCPU RAM arbiter
interface mcpu_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req0, req1, we0, we1, lock0, lock1;
  logic [ADDR_WIDTH-1:0] addr0, addr1, ram_addr;
  logic [DATA_WIDTH-1:0] wdata0, wdata1, rdata, ram_wdata, ram_rdata;
  logic                  gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mcpu_ram_arbiter.sv
// mcpu_ram_arbiter: round-robin/locking two-port arbiter for the MCPU RAM (MCPU_ARB_FIXED_PRIO_EN selects fixed port-0 priority)
module mcpu_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 15
) (
  input  logic clk,
  input  logic reset,
  mcpu_ram_arbiter_if.slave bus
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;
  state_t        state;
  logic          rr_ptr, prefer1, g, sel, lk, rel, rd_v, rd_p;
  logic [CW-1:0] lock_cnt, cnt_nx;
`ifdef MCPU_ARB_FIXED_PRIO_EN
  assign prefer1 = 1'b0;
`else
  assign prefer1 = rr_ptr;
`endif
  assign bus.gnt0  = bus.req0 & ((state == LOCKED0) | ((state == UNLOCKED) & !(bus.req1 & prefer1)));
  assign bus.gnt1  = bus.req1 & ((state == LOCKED1) | ((state == UNLOCKED) & !(bus.req0 & !prefer1)));
  assign bus.rdata = bus.ram_rdata;
  assign g         = bus.gnt0 | bus.gnt1;
  assign sel       = bus.gnt1;
  assign lk        = sel ? bus.lock1 : bus.lock0;
  assign cnt_nx    = lock_cnt + 1'b1;
  assign rel       = !lk || (cnt_nx >= LMAX);
  // lock FSM, round-robin pointer, registered RAM command and 2-stage read tag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= UNLOCKED;
      rr_ptr        <= 1'b0;
      lock_cnt      <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      rd_v          <= 1'b0;
      rd_p          <= 1'b0;
      bus.rvalid0   <= 1'b0;
      bus.rvalid1   <= 1'b0;
    end else begin
      bus.ram_en  <= g;
      bus.ram_we  <= g & (sel ? bus.we1 : bus.we0);
      rd_v        <= g & !(sel ? bus.we1 : bus.we0);
      rd_p        <= sel;
      bus.rvalid0 <= rd_v & !rd_p;
      bus.rvalid1 <= rd_v & rd_p;
      if (g) begin
        bus.ram_addr  <= sel ? bus.addr1 : bus.addr0;
        bus.ram_wdata <= sel ? bus.wdata1 : bus.wdata0;
        rr_ptr        <= !sel;
        state         <= rel ? UNLOCKED : (sel ? LOCKED1 : LOCKED0);
        lock_cnt      <= rel ? '0 : cnt_nx;
      end
    end
endmodule
